// File: rtl/sound_cmd_latch.sv
// Z80-side end of the 68000 -> sound command path: byte latch, read-status flags and the
// SNDON-driven Z80 interrupt with optional auto-clear timeout.
module sound_cmd_latch #(
   parameter int unsigned IRQ_TIMEOUT = 0,
   parameter int unsigned TO_W        = 16
) (
   input  logic       clk_main,
   input  logic       reset,
   input  logic       snddt_n,
   input  logic [7:0] cpu_din,
   input  logic       sndon,
   input  logic       z80_latch_rd_n,
   input  logic       z80_m1_n,
   input  logic       z80_iorq_n,
   output logic [7:0] z80_dout,
   output logic       z80_dout_en,
   output logic       z80_int_n,
   output logic       cmd_unread,
   output logic       cmd_overrun
);

   typedef enum logic [0:0] {StIdle, StPend} irq_state_e;

   localparam bit            ToEnable = (IRQ_TIMEOUT != 0);
   localparam logic [TO_W-1:0] ToLast = TO_W'(IRQ_TIMEOUT - 1);

   irq_state_e      irq_state;
   logic [TO_W-1:0] to_cnt;
   logic            snddt_prev;
   logic            wr_armed;
   logic            rd_prev;
   logic            iack_prev;
   logic            sndon_prev;

   logic iack;
   logic wr_edge;
   logic rd_edge;
   logic irq_req;
   logic iack_edge;
   logic timeout_hit;

   // wr_armed blocks a capture from a strobe that was already low when reset released.
   always_comb begin
      iack        = z80_m1_n | z80_iorq_n;
      wr_edge     = wr_armed & snddt_prev & ~snddt_n;
      rd_edge     = rd_prev & ~z80_latch_rd_n;
      irq_req     = sndon & ~sndon_prev;
      iack_edge   = iack_prev & ~iack;
      timeout_hit = ToEnable && (to_cnt == ToLast);
   end

   always_ff @(posedge clk_main) begin
      if (reset) begin
         z80_dout    <= 8'h00;
         z80_dout_en <= 1'b0;
         cmd_unread  <= 1'b0;
         cmd_overrun <= 1'b0;
         snddt_prev  <= 1'b1;
         wr_armed    <= snddt_n;
         rd_prev     <= 1'b1;
         iack_prev   <= 1'b1;
         sndon_prev  <= 1'b0;
      end else begin
         snddt_prev  <= snddt_n;
         wr_armed    <= wr_armed | snddt_n;
         rd_prev     <= z80_latch_rd_n;
         iack_prev   <= iack;
         sndon_prev  <= sndon;
         z80_dout_en <= ~z80_latch_rd_n;
         if (wr_edge) begin
            z80_dout   <= cpu_din;
            cmd_unread <= 1'b1;
            if (cmd_unread && !rd_edge) cmd_overrun <= 1'b1;
         end else if (rd_edge) begin
            cmd_unread <= 1'b0;
         end
      end
   end

   // A new request always wins over acknowledge or timeout and restarts the counter.
   always_ff @(posedge clk_main) begin
      if (reset) begin
         irq_state <= StIdle;
         z80_int_n <= 1'b1;
         to_cnt    <= '0;
      end else if (irq_req) begin
         irq_state <= StPend;
         z80_int_n <= 1'b0;
         to_cnt    <= '0;
      end else begin
         unique case (irq_state)
            StIdle: begin
               z80_int_n <= 1'b1;
            end
            StPend: begin
               if (iack_edge || timeout_hit) begin
                  irq_state <= StIdle;
                  z80_int_n <= 1'b1;
               end else if (to_cnt != '1) begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            default: begin
               irq_state <= StIdle;
               z80_int_n <= 1'b1;
            end
         endcase
      end
   end

endmodule
